// File: rtl/sram_stream_reader.sv
// sram_stream_reader: streams LEN words from a synchronous SRAM read
// port, starting at BASE_ADDR, into a valid/ready sink via a 4-deep FIFO.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   START, BASE_ADDR, LEN   transfer request (sampled in IDLE)
//   BUSY, DONE        transfer active / one-cycle completion pulse
//   ENB, ADDRB, DOUTB SRAM read port (data valid one cycle after ENB)
//   M_VALID, M_READY, M_DATA, M_LAST   output stream
//   ABORT             only when SRAM_READER_ABORT_EN is defined
module sram_stream_reader #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [AWIDTH-1:0] BASE_ADDR,
  input  logic [AWIDTH:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ENB,
  output logic [AWIDTH-1:0] ADDRB,
  input  logic [DWIDTH-1:0] DOUTB,
  output logic              M_VALID,
  input  logic              M_READY,
`ifdef SRAM_READER_ABORT_EN
  input  logic              ABORT,
`endif
  output logic [DWIDTH-1:0] M_DATA,
  output logic              M_LAST
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [AWIDTH:0]   L_ONE = 1;
  localparam logic [AWIDTH-1:0] A_ONE = 1;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_enb;
  logic              r_cap;
  logic [AWIDTH-1:0] r_addr;
  logic [AWIDTH:0]   r_rd_left;
  logic [AWIDTH:0]   r_out_left;
  logic [DWIDTH-1:0] r_mem [4];
  logic [1:0]        r_wp;
  logic [1:0]        r_rp;
  logic [2:0]        r_cnt;

  logic              w_vld;
  logic              w_pop;
  logic              w_last;
  logic [3:0]        w_pend;
  logic              w_room;
  logic              w_abort;

  assign w_vld  = (r_cnt != 3'd0);
  assign w_pop  = w_vld && M_READY;
  assign w_last = w_vld && (r_out_left == L_ONE);

  // FIFO words plus reads whose data has not landed yet:
  // r_enb is the read on the bus now, r_cap the one landing this edge.
  assign w_pend = {1'b0, r_cnt} + {3'b0, r_enb} + {3'b0, r_cap};
  assign w_room = (w_pend < 4'd4);

`ifdef SRAM_READER_ABORT_EN
  assign w_abort = ABORT && r_busy;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (r_cap) begin
      r_mem[r_wp] <= DOUTB;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_enb      <= 1'b0;
      r_cap      <= 1'b0;
      r_addr     <= '0;
      r_rd_left  <= '0;
      r_out_left <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
    end else if (w_abort) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b1;
      r_enb      <= 1'b0;
      r_cap      <= 1'b0;
      r_rd_left  <= '0;
      r_out_left <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
    end else begin
      r_done <= 1'b0;
      r_enb  <= 1'b0;
      r_cap  <= r_enb;
      if (r_cap) begin
        r_wp <= r_wp + 2'd1;
      end
      if (w_pop) begin
        r_rp       <= r_rp + 2'd1;
        r_out_left <= r_out_left - L_ONE;
      end
      r_cnt <= r_cnt + {2'b0, r_cap} - {2'b0, w_pop};
      unique case (r_state)
        S_IDLE: begin
          if (START) begin
            if (LEN != '0) begin
              r_state    <= S_RUN;
              r_busy     <= 1'b1;
              r_enb      <= 1'b1;
              r_addr     <= BASE_ADDR;
              r_rd_left  <= LEN - L_ONE;
              r_out_left <= LEN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (r_rd_left == '0) begin
            r_state <= S_DRAIN;
          end else if (w_room) begin
            r_enb     <= 1'b1;
            r_addr    <= r_addr + A_ONE;
            r_rd_left <= r_rd_left - L_ONE;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign ENB     = r_enb;
  assign ADDRB   = r_addr;
  assign M_VALID = w_vld;
  assign M_DATA  = w_vld ? r_mem[r_rp] : '0;
  assign M_LAST  = w_last;

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb_sram_stream_reader: randomized and directed checks of
// sram_stream_reader against an SRAM array and address/word model.
module tb_sram_stream_reader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [4:0]  BASE_ADDR = '0;
  logic [5:0]  LEN = '0;
  logic        BUSY;
  logic        DONE;
  logic        ENB;
  logic [4:0]  ADDRB;
  logic [31:0] DOUTB = '0;
  logic        M_VALID;
  logic        M_READY = 1'b1;
  logic [31:0] M_DATA;
  logic        M_LAST;
  logic        ABORT = 1'b0;

  sram_stream_reader #(.DWIDTH(32), .AWIDTH(5)) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .BASE_ADDR(BASE_ADDR),
    .LEN(LEN),
    .BUSY(BUSY),
    .DONE(DONE),
    .ENB(ENB),
    .ADDRB(ADDRB),
    .DOUTB(DOUTB),
    .M_VALID(M_VALID),
    .M_READY(M_READY),
`ifdef SRAM_READER_ABORT_EN
    .ABORT(ABORT),
`endif
    .M_DATA(M_DATA),
    .M_LAST(M_LAST)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [32];
  always @(posedge CLK) begin
    if (ENB) DOUTB <= mem[ADDRB];
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp,
               $time);
    end
  endtask

  int q_addr[$];
  int q_acyc[$];
  int q_data[$];
  int q_last[$];
  int q_dcyc[$];
  int q_done[$];
  int q_dbusy[$];
  int n_busy;
  int n_vld;

  logic        p_vld = 0;
  logic        p_rdy = 0;
  logic        p_rst = 1;
  logic        p_abt = 0;
  logic [31:0] p_data = 0;
  logic        p_last = 0;

  task automatic clr();
    q_addr.delete();
    q_acyc.delete();
    q_data.delete();
    q_last.delete();
    q_dcyc.delete();
    q_done.delete();
    q_dbusy.delete();
    n_busy = 0;
    n_vld = 0;
  endtask

  always @(negedge CLK) begin
    if (ENB) begin
      q_addr.push_back(int'(ADDRB));
      q_acyc.push_back(cyc);
    end
    if (M_VALID && M_READY) begin
      q_data.push_back(int'(M_DATA));
      q_last.push_back(int'(M_LAST));
      q_dcyc.push_back(cyc);
    end
    if (DONE) begin
      q_done.push_back(cyc);
      q_dbusy.push_back(int'(BUSY));
    end
    if (BUSY) n_busy++;
    if (M_VALID) n_vld++;
    if (p_vld && !p_rdy && !p_rst && !p_abt) begin
      chk("hold_valid", M_VALID, 1);
      chk("hold_data", M_DATA, p_data);
      chk("hold_last", M_LAST, p_last);
    end
    p_vld  = M_VALID;
    p_rdy  = M_READY;
    p_rst  = RST;
    p_abt  = ABORT;
    p_data = M_DATA;
    p_last = M_LAST;
  end

  function automatic logic rdy(input int mode, input int rel);
    if (mode == 0) return 1'b1;
    if (mode == 2) return !(rel >= 3 && rel <= 12);
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic xfer(input int base, input int len, input int mode);
    int c0;
    int rel;
    int n;
    logic ok;
    clr();
    @(posedge CLK); #1;
    START = 1'b1;
    BASE_ADDR = 5'(base);
    LEN = 6'(len);
    M_READY = 1'b1;
    c0 = cyc;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      rel = cyc - c0;
      M_READY = rdy(mode, rel);
      if (q_done.size() != 0) begin
        ok = 1'b1;
        break;
      end
    end
    M_READY = 1'b1;
    chk("timeout", ok, 1);
    chk("n_reads", q_addr.size(), len);
    chk("n_words", q_data.size(), len);
    chk("n_done", q_done.size(), 1);
    for (int i = 0; i < len && i < q_addr.size(); i++)
      chk("addr", q_addr[i], (base + i) % 32);
    for (int i = 0; i < len && i < q_data.size(); i++) begin
      chk("data", q_data[i], mem[(base + i) % 32]);
      chk("last", q_last[i], (i == len - 1) ? 1 : 0);
    end
    for (int i = 0; i + 4 < len && i + 4 < q_acyc.size() &&
         i < q_dcyc.size(); i++)
      chk("window", (q_acyc[i+4] >= q_dcyc[i] + 2) ? 1 : 0, 1);
    if (q_done.size() == 1 && q_dcyc.size() == len) begin
      chk("done_cyc", q_done[0], q_dcyc[len-1] + 1);
      chk("done_busy", q_dbusy[0], 0);
      chk("busy_cnt", n_busy, q_dcyc[len-1] - c0);
    end
    if (mode == 0) begin
      for (int i = 0; i < q_acyc.size(); i++)
        chk("rd_cyc", q_acyc[i] - c0, 1 + i);
      for (int i = 0; i < q_dcyc.size(); i++)
        chk("wd_cyc", q_dcyc[i] - c0, 3 + i);
      if (q_done.size() > 0)
        chk("done_rel", q_done[0] - c0, 3 + len);
    end
    if (mode == 2) begin
      n = 0;
      foreach (q_acyc[i]) if (q_acyc[i] - c0 <= 13) n++;
      chk("stall_reads", (n <= 4) ? 1 : 0, 1);
    end
  endtask

  initial begin
    int c0;
    logic ok;
    foreach (mem[i]) mem[i] = $urandom;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_enb", ENB, 0);
    chk("rst_addr", ADDRB, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_valid", M_VALID, 0);
    chk("rst_data", M_DATA, 0);
    chk("rst_last", M_LAST, 0);
    RST = 1'b0;

    xfer(3, 4, 0);
    xfer(30, 5, 0);
    xfer(5, 8, 2);
    xfer(0, 1, 0);
    xfer(1, 32, 0);

    clr();
    @(posedge CLK); #1;
    START = 1'b1;
    LEN = 6'd0;
    BASE_ADDR = 5'd9;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    chk("len0_done", DONE, 1);
    repeat (5) @(posedge CLK);
    #1;
    chk("len0_reads", q_addr.size(), 0);
    chk("len0_busy", n_busy, 0);
    chk("len0_valid", n_vld, 0);
    chk("len0_ndone", q_done.size(), 1);

    clr();
    @(posedge CLK); #1;
    START = 1'b1;
    BASE_ADDR = 5'd7;
    LEN = 6'd10;
    c0 = cyc;
    repeat (4) begin
      @(posedge CLK); #1;
      START = 1'b0;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("mrst_enb", ENB, 0);
    chk("mrst_valid", M_VALID, 0);
    chk("mrst_busy", BUSY, 0);
    repeat (8) @(posedge CLK);
    #1;
    chk("mrst_ndone", q_done.size(), 0);
    foreach (q_acyc[i]) chk("mrst_rd", (q_acyc[i] - c0 <= 4) ? 1 : 0, 1);
    xfer(9, 2, 0);

    clr();
    @(posedge CLK); #1;
    START = 1'b1;
    BASE_ADDR = 5'd0;
    LEN = 6'd2;
    @(posedge CLK); #1;
    START = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (DONE) begin
        ok = 1'b1;
        break;
      end
    end
    chk("chain_done1", ok, 1);
    START = 1'b1;
    BASE_ADDR = 5'd20;
    LEN = 6'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    chk("chain_enb", ENB, 1);
    chk("chain_addr", ADDRB, 20);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge CLK); #1;
      if (q_done.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("chain_done2", ok, 1);
    chk("chain_n", q_data.size(), 5);
    if (q_data.size() == 5) begin
      chk("chain_w0", q_data[0], mem[0]);
      chk("chain_w1", q_data[1], mem[1]);
      for (int i = 0; i < 3; i++)
        chk("chain_wb", q_data[2+i], mem[20+i]);
    end

`ifdef SRAM_READER_ABORT_EN
    clr();
    @(posedge CLK); #1;
    START = 1'b1;
    BASE_ADDR = 5'd11;
    LEN = 6'd16;
    c0 = cyc;
    repeat (5) begin
      @(posedge CLK); #1;
      START = 1'b0;
    end
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    @(negedge CLK);
    chk("abt_valid", M_VALID, 0);
    chk("abt_done", DONE, 1);
    chk("abt_busy", BUSY, 0);
    repeat (6) @(posedge CLK);
    #1;
    chk("abt_ndone", q_done.size(), 1);
    foreach (q_acyc[i]) chk("abt_rd", (q_acyc[i] - c0 <= 5) ? 1 : 0, 1);
    xfer(2, 3, 0);
`endif

    for (int t = 0; t < 20; t++) begin
      if (t % 5 == 0) foreach (mem[i]) mem[i] = $urandom;
      xfer(int'($urandom_range(0, 31)), int'($urandom_range(1, 32)),
           int'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
